// File: rtl/vga_vram_arbiter_if.sv
// rtl/vga_vram_arbiter_if.sv - scanout, CPU bus and VRAM port signals of vga_vram_arbiter
interface vga_vram_arbiter_if #(
  parameter int AW = 13,
  parameter int DW = 8
);
  logic          vid_req;
  logic [AW-1:0] vid_addr;
  logic          vid_valid;
  logic [DW-1:0] vid_rdata;

  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_ready;
  logic          cpu_rvalid;
  logic [DW-1:0] cpu_rdata;

  logic          wbuf_empty;
  logic          wbuf_full;

  logic          ram_en;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  logic [15:0]   stall_cnt;

  modport master (
    output vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_rdata,
    input  vid_valid, vid_rdata, cpu_ready, cpu_rvalid, cpu_rdata,
           wbuf_empty, wbuf_full, ram_en, ram_we, ram_addr, ram_wdata, stall_cnt
  );

  modport slave (
    input  vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_rdata,
    output vid_valid, vid_rdata, cpu_ready, cpu_rvalid, cpu_rdata,
           wbuf_empty, wbuf_full, ram_en, ram_we, ram_addr, ram_wdata, stall_cnt
  );
endinterface

// File: rtl/vga_vram_arbiter.sv
// rtl/vga_vram_arbiter.sv - single-port VRAM arbiter: scanout first, posted CPU writes, then CPU reads
// Optional stall counter enabled by defining VGA_VRAM_ARB_STATS_EN.
module vga_vram_arbiter #(
  parameter int AW         = 13,
  parameter int DW         = 8,
  parameter int WBUF_DEPTH = 4
) (
  input  logic            clk_25,
  input  logic            rst_n,
  vga_vram_arbiter_if.slave bus
);
  localparam int PW = $clog2(WBUF_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(WBUF_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_RD_ISSUE, S_RD_RET} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] wb_addr [WBUF_DEPTH];
  logic [DW-1:0] wb_data [WBUF_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] wb_count, count_d;
  logic          rd_pending, rd_pending_d;
  logic [AW-1:0] rd_addr;
  logic          vid_valid_q;
  logic [DW-1:0] cpu_rdata_q;
  logic          wb_full;
  logic          push, pop, rd_accept, rd_issue;

  assign wb_full = (wb_count == FULL_CNT);

  // The state always names the operation owed to the RAM; scanout simply pre-empts it for a cycle.
  always_comb begin
    state_d       = state_q;
    pop           = 1'b0;
    rd_issue      = 1'b0;
    bus.ram_en    = 1'b0;
    bus.ram_we    = 1'b0;
    bus.ram_addr  = '0;
    bus.ram_wdata = wb_data[rd_ptr];

    if (bus.vid_req) begin
      bus.ram_en   = 1'b1;
      bus.ram_addr = bus.vid_addr;
    end else begin
      case (state_q)
        S_DRAIN: begin
          pop          = 1'b1;
          bus.ram_en   = 1'b1;
          bus.ram_we   = 1'b1;
          bus.ram_addr = wb_addr[rd_ptr];
        end
        S_RD_ISSUE: begin
          rd_issue     = 1'b1;
          bus.ram_en   = 1'b1;
          bus.ram_addr = rd_addr;
        end
        default: ;
      endcase
    end

    bus.cpu_ready = bus.cpu_we ? (!wb_full && !rd_pending) : !rd_pending;
    push          = bus.cpu_req &&  bus.cpu_we && bus.cpu_ready;
    rd_accept     = bus.cpu_req && !bus.cpu_we && bus.cpu_ready;
    count_d       = wb_count + CW'(push) - CW'(pop);
    rd_pending_d  = rd_accept || (rd_pending && !rd_issue);

    if (rd_issue)           state_d = S_RD_RET;
    else if (count_d != '0) state_d = S_DRAIN;
    else if (rd_pending_d)  state_d = S_RD_ISSUE;
    else                    state_d = S_IDLE;
  end

  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      wb_count    <= '0;
      rd_pending  <= 1'b0;
      rd_addr     <= '0;
      vid_valid_q <= 1'b0;
      cpu_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      wb_count    <= count_d;
      rd_pending  <= rd_pending_d;
      vid_valid_q <= bus.vid_req;
      if (push)      wr_ptr  <= wr_ptr + 1'b1;
      if (pop)       rd_ptr  <= rd_ptr + 1'b1;
      if (rd_accept) rd_addr <= bus.cpu_addr;
      if (state_q == S_RD_RET) cpu_rdata_q <= bus.ram_rdata;
    end
  end

  always_ff @(posedge clk_25) begin
    if (push) begin
      wb_addr[wr_ptr] <= bus.cpu_addr;
      wb_data[wr_ptr] <= bus.cpu_wdata;
    end
  end

  assign bus.vid_valid  = vid_valid_q;
  assign bus.vid_rdata  = vid_valid_q ? bus.ram_rdata : '0;
  assign bus.cpu_rvalid = (state_q == S_RD_RET);
  assign bus.cpu_rdata  = bus.cpu_rvalid ? bus.ram_rdata : cpu_rdata_q;
  assign bus.wbuf_empty = (wb_count == '0);
  assign bus.wbuf_full  = wb_full;

`ifdef VGA_VRAM_ARB_STATS_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n)
      stall_q <= 16'h0000;
    else if (state_q == S_RD_RET)
      stall_q <= 16'h0000;
    else if ((wb_count != '0 || rd_pending) && bus.vid_req && stall_q != 16'hFFFF)
      stall_q <= stall_q + 16'h0001;
  end

  assign bus.stall_cnt = stall_q;
`else
  assign bus.stall_cnt = 16'h0000;
`endif
endmodule

// File: tb/tb_vga_vram_arbiter.sv
// tb/tb_vga_vram_arbiter.sv - randomized and directed bench for vga_vram_arbiter against a queue-based model
module tb_vga_vram_arbiter;
  localparam int AW = 13;
  localparam int DW = 8;
  localparam int D  = 4;

  logic clk_25 = 1'b0;
  logic rst_n  = 1'b0;
  always #20 clk_25 = ~clk_25;

  vga_vram_arbiter_if #(.AW(AW), .DW(DW)) bus();

  vga_vram_arbiter #(.AW(AW), .DW(DW), .WBUF_DEPTH(D)) dut (
    .clk_25 (clk_25),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  logic [DW-1:0] mem [2**AW];

  // Synchronous single-port RAM with one cycle of read latency.
  always @(posedge clk_25) begin
    if (bus.ram_en) begin
      if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
      else            bus.ram_rdata     <= mem[bus.ram_addr];
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0]    shadow [2**AW];
  logic [AW+DW-1:0] wq[$];
  bit               rp, rret, vprev, last_acc;
  logic [AW-1:0]    rp_addr;
  logic [DW-1:0]    rexp, rlast, vexp;
  int               stall_m;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    wq.delete();
    rp = 0; rret = 0; vprev = 0; rlast = '0; stall_m = 0;
    for (int i = 0; i < 2**AW; i++) shadow[i] = mem[i];
  endtask

  // One clock cycle: drive inputs, compare outputs with the model, advance the model.
  task automatic step(input bit req, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                      input bit vr, input logic [AW-1:0] va);
    bit               exp_ready, nrret, busy;
    logic [AW+DW-1:0] hd;
    int               exp_stall;
    @(negedge clk_25);
    bus.cpu_req = req; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = wd;
    bus.vid_req = vr;  bus.vid_addr = va;
    #1;
    exp_ready = we ? (wq.size() < D && !rp) : !rp;
    busy      = (wq.size() != 0) || rp;
`ifdef VGA_VRAM_ARB_STATS_EN
    exp_stall = stall_m;
`else
    exp_stall = 0;
`endif
    chk("cpu_ready",  32'(bus.cpu_ready),  32'(exp_ready));
    chk("wbuf_empty", 32'(bus.wbuf_empty), 32'(wq.size() == 0));
    chk("wbuf_full",  32'(bus.wbuf_full),  32'(wq.size() == D));
    chk("cpu_rvalid", 32'(bus.cpu_rvalid), 32'(rret));
    chk("cpu_rdata",  32'(bus.cpu_rdata),  32'(rret ? rexp : rlast));
    chk("vid_valid",  32'(bus.vid_valid),  32'(vprev));
    if (vprev) chk("vid_rdata", 32'(bus.vid_rdata), 32'(vexp));
    chk("stall_cnt",  32'(bus.stall_cnt),  32'(exp_stall));

    nrret = 0;
    if (vr) begin
      chk("vid_ram_en", 32'(bus.ram_en), 32'd1);
      chk("vid_ram_we", 32'(bus.ram_we), 32'd0);
      chk("vid_ram_addr", 32'(bus.ram_addr), 32'(va));
      vexp = mem[va];
    end else if (wq.size() != 0) begin
      hd = wq.pop_front();
      chk("wr_ram_en", 32'(bus.ram_en), 32'd1);
      chk("wr_ram_we", 32'(bus.ram_we), 32'd1);
      chk("wr_ram_addr", 32'(bus.ram_addr), 32'(hd[AW+DW-1:DW]));
      chk("wr_ram_wdata", 32'(bus.ram_wdata), 32'(hd[DW-1:0]));
    end else if (rp) begin
      chk("rd_ram_en", 32'(bus.ram_en), 32'd1);
      chk("rd_ram_we", 32'(bus.ram_we), 32'd0);
      chk("rd_ram_addr", 32'(bus.ram_addr), 32'(rp_addr));
      rp = 0; nrret = 1;
    end else begin
      chk("idle_ram_en", 32'(bus.ram_en), 32'd0);
    end

    if (rret) begin
      rlast   = rexp;
      stall_m = 0;
    end else if (busy && vr && stall_m < 65535) begin
      stall_m++;
    end

    last_acc = req && exp_ready;
    if (last_acc) begin
      if (we) begin
        wq.push_back({a, wd});
        shadow[a] = wd;
      end else begin
        rp = 1; rp_addr = a; rexp = shadow[a];
      end
    end
    vprev = vr;
    rret  = nrret;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, '0, '0, 0, '0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_wbuf_empty"}, 32'(bus.wbuf_empty), 32'd1);
    chk({tag, "_wbuf_full"},  32'(bus.wbuf_full),  32'd0);
    chk({tag, "_vid_valid"},  32'(bus.vid_valid),  32'd0);
    chk({tag, "_vid_rdata"},  32'(bus.vid_rdata),  32'd0);
    chk({tag, "_cpu_rvalid"}, 32'(bus.cpu_rvalid), 32'd0);
    chk({tag, "_cpu_rdata"},  32'(bus.cpu_rdata),  32'd0);
    chk({tag, "_stall_cnt"},  32'(bus.stall_cnt),  32'd0);
    chk({tag, "_ram_en"},     32'(bus.ram_en),     32'd0);
    chk({tag, "_ram_we"},     32'(bus.ram_we),     32'd0);
  endtask

  initial begin
    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.vid_req = 0; bus.vid_addr = '0;
    for (int i = 0; i < 2**AW; i++) mem[i] = 8'(i * 7 + 3);
    mem[13'h0010] = 8'hA5; mem[13'h0011] = 8'h5A; mem[13'h0012] = 8'h3C;
    #30;
    check_reset_outputs("reset");
    model_reset();
    @(negedge clk_25);
    rst_n = 1'b1;

    // Scanout burst over preloaded data.
    step(0, 0, '0, '0, 1, 13'h0010);
    step(0, 0, '0, '0, 1, 13'h0011);
    step(0, 0, '0, '0, 1, 13'h0012);
    chk("scan_first_data", 32'(bus.vid_rdata), 32'h5A);
    idle(2);

    // Back-to-back posted writes with no scanout.
    for (int i = 0; i < 4; i++) step(1, 1, 13'(13'h0100 + i), 8'(8'h11 * (i + 1)), 0, '0);
    idle(3);
    chk("drained_0103", 32'(mem[13'h0103]), 32'h44);

    // Fill the buffer under scanout, then let it drain and take the fifth write.
    for (int i = 0; i < 5; i++) step(1, 1, 13'(13'h0180 + i), 8'(8'hC0 + i), 1, 13'(i));
    chk("fifth_write_blocked", 32'(last_acc), 32'd0);
    for (int i = 0; i < 10 && !last_acc; i++) step(1, 1, 13'h0184, 8'hC4, 0, '0);
    chk("fifth_write_taken", 32'(last_acc), 32'd1);
    idle(4);

    // Read-after-write with scanout pulses in between.
    step(1, 1, 13'h0200, 8'h77, 0, '0);
    step(1, 0, 13'h0200, '0, 1, 13'h0020);
    step(0, 0, '0, '0, 1, 13'h0021);
    idle(4);
    chk("raw_rdata", 32'(bus.cpu_rdata), 32'h77);

    // Read held off by ten cycles of scanout.
    step(1, 0, 13'h0100, '0, 0, '0);
    for (int i = 0; i < 10; i++) step(0, 0, '0, '0, 1, 13'(i));
    idle(4);
    chk("stall_read_data", 32'(bus.cpu_rdata), 32'h11);

    // Reset with two buffered writes and a pending read.
    step(1, 1, 13'h0300, 8'hAA, 1, '0);
    step(1, 1, 13'h0301, 8'hBB, 1, '0);
    step(1, 0, 13'h0300, '0, 1, '0);
    @(negedge clk_25);
    bus.cpu_req = 0; bus.vid_req = 0;
    #5 rst_n = 1'b0;
    #1 check_reset_outputs("midrst");
    model_reset();
    @(negedge clk_25);
    rst_n = 1'b1;
    idle(4);
    chk("discarded_write", 32'(mem[13'h0300] == 8'hAA), 32'd0);

    // Random traffic over a small address window to provoke hazards.
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 99) < 45, $urandom_range(0, 1) == 1,
           13'($urandom_range(0, 15)), 8'($urandom),
           $urandom_range(0, 99) < 40, 13'($urandom_range(0, 31)));
    end
    idle(12);
    for (int i = 0; i < 16; i++) chk("final_mem", 32'(mem[i]), 32'(shadow[i]));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
